// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and counter sizing for the serial adder
package adder_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int cnt_width(int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: full adder built from two half_adder cells
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic s0, c0, c1;
   half_adder u_ha0 (.a(a), .b(b), .s(s0), .c(c0));
   half_adder u_ha1 (.a(s0), .b(cin), .s(s), .c(c1));
   assign cout = c0 | c1;
endmodule

// File: rtl/half_adder.sv
// half_adder: one-bit half adder cell
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with valid/ready handshakes on both sides
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int CW = cnt_width(WIDTH);
   state_t state;
   logic [WIDTH-1:0] a_sh, b_sh, acc_sh, acc_nxt;
   logic [CW-1:0] cnt;
   logic carry, fa_s, fa_c;
   full_adder_cell u_fa (.a(a_sh[0]), .b(b_sh[0]), .cin(carry), .s(fa_s), .cout(fa_c));
   // sum bits enter at the MSB and shift down so bit 0 lands in place after WIDTH steps
   generate
      if (WIDTH == 1) begin : g_one
         assign acc_nxt = fa_s;
      end else begin : g_many
         assign acc_nxt = {fa_s, acc_sh[WIDTH-1:1]};
      end
   endgenerate
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         acc_sh    <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sh     <= a;
               b_sh     <= b;
               carry    <= cin;
               cnt      <= '0;
               state    <= RUN;
               in_ready <= 1'b0;
               busy     <= 1'b1;
            end
            RUN: begin
               acc_sh <= acc_nxt;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_c;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  sum       <= acc_nxt;
                  cout      <= fa_c;
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end
endmodule
